split_frame_length: RTL and testbench
=====================================

# split_frame_length

Splits a merged AXI4-Stream carrying a fixed-size frame-length header followed by an Ethernet frame ([Frame length]/[Ethernet Frame]) into two streams: one for the frame-length beats and one for the frame data. It also latches the decoded length and checks it against the number of data beats actually received. It sits at the consumer end of the ATS path, wherever the length-prefixed stream must be separated again before the length-driven scheduling logic and the frame FIFO.

## Interface
- DATA_WIDTH, 8, tdata width of all streams.
- LENGTH_BEATS, 2, number of header beats per frame (≥1); the length field is LENGTH_BEATS*DATA_WIDTH bits, big-endian.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  merged input stream.
- m_axis_frame_length_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  header beats; tlast set on the last header beat.
- m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  Ethernet frame beats.
- frame_length  out  LENGTH_BEATS*DATA_WIDTH  length of the most recent header; updates once per header.
- frame_length_valid  out  1  one-cycle pulse, the cycle after the last header beat handshake.
- err_short  out  1  one-cycle pulse: the frame ended with fewer beats than frame_length.
- err_long  out  1  one-cycle pulse: the frame ended with more beats than frame_length.
- err_header  out  1  one-cycle pulse: input tlast was seen on a header beat.
- frame_count, err_count  out  16  saturating counters.

## Operation
- **States.** The block has two states, HDR (with header index hidx from 0 to LENGTH_BEATS-1) and DATA. Reset state is HDR with hidx=0.
- **HDR routing (combinational, zero latency):**
  - m_axis_frame_length_tdata = s_axis_tdata.
  - m_axis_frame_length_tvalid = s_axis_tvalid.
  - s_axis_tready = m_axis_frame_length_tready.
  - m_axis_frame_length_tlast = (hidx==LENGTH_BEATS-1).
  - m_axis_tvalid = 0.
- **DATA routing:**
  - m_axis_tdata/tvalid/tlast follow s_axis.
  - s_axis_tready = m_axis_tready.
  - m_axis_frame_length_tvalid = 0.
- **Header assembly.** On each HDR handshake, the beat is shifted into a length shift register (first beat = MSBs) and hidx increments.
- **HDR → DATA.** On the handshake of the last header beat:
  - frame_length is loaded with the assembled value.
  - frame_length_valid pulses.
  - State moves to DATA, hidx resets to 0, and the beat counter is cleared.
- **DATA counting.** Each DATA handshake increments the beat counter. The counter has the same width as frame_length and saturates at its maximum.
- **DATA → HDR (on tlast handshake).** Let n = beats including the tlast beat:
  - n < frame_length: err_short pulses.
  - n > frame_length: err_long pulses.
  - frame_count increments.
  - State returns to HDR.
  - The frame is always forwarded complete, including tlast, regardless of mismatch.
- **Malformed header.** If s_axis_tlast=1 on a HDR handshake:
  - The beat is forwarded with m_axis_frame_length_tlast=1.
  - err_header pulses.
  - frame_length is not updated and frame_length_valid does not pulse.
  - hidx resets to 0 and the state stays HDR (no data phase).
- **Error counter.** err_count increments once per cycle in which any error pulse fires; it saturates at 16'hFFFF.
- **Idle.** When tvalid is deasserted mid-header or mid-frame, the state holds and nothing is emitted.

## Timing
- Data paths are purely combinational: no buffering and no added latency. tready on the input is a pure function of state and the selected downstream tready.
- The state, hidx, counters and frame_length update at the clk edge of the handshake.
- All pulses (frame_length_valid, err_*) are registered: they are high exactly one cycle, the cycle after the triggering handshake.
- Back-to-back frames are allowed: the first header beat of the next frame may handshake the cycle right after a data tlast.
- **Reset values:**
  - state=HDR, hidx=0.
  - frame_length=0.
  - frame_length_valid=0 and all err_*=0.
  - frame_count=0, err_count=0.
  - Combinational outputs follow HDR routing: m_axis_tvalid=0, and m_axis_frame_length_tvalid = s_axis_tvalid.
- **Reset mid-frame.** The partial frame is abandoned, with no tlast generated. Downstream consumers are reset in the same domain.
- **Zero-length header.** A frame_length of 0 followed by any data frame gives err_long, since n ≥ 1.

## Test plan
- **Nominal frame.** DATA_WIDTH=8, LENGTH_BEATS=2, input 0x00,0x40 then 64 data beats with tlast on beat 64, both outputs always ready.
  - Length stream carries 0x00, 0x40 with tlast on 0x40.
  - frame_length=0x0040, with frame_length_valid pulsing 1 cycle later.
  - 64 beats appear on m_axis.
  - No errors; frame_count=1.
- **Short frame.** Header 0x00,0x40 followed by 60 beats ending in tlast.
  - err_short pulses once; err_count=1.
  - All 60 beats are forwarded.
- **Long frame and back-to-back.** Header 0x00,0x03 with 5 beats, immediately followed by header 0x00,0x02 with 2 beats.
  - err_long fires for the first frame only.
  - frame_length reads 3 and then 2.
  - frame_count=2, and no idle cycle is inserted.
- **Backpressure.** Toggle m_axis_frame_length_tready and m_axis_tready randomly at 50%.
  - s_axis_tready mirrors the ready of the active output each cycle.
  - No beat is dropped or duplicated; the output byte sequences equal the input.
- **Malformed header.** Drive tlast=1 on the first header beat.
  - err_header pulses.
  - The length stream sees that beat with tlast=1.
  - m_axis stays idle, and the next 2-beat header parses correctly.
- **Reset mid-frame.** Assert rstn=0 for one cycle after 10 of 64 data beats.
  - All registers return to reset values and the state is HDR.
  - A following header plus frame is processed normally.

Source files
------------

// File: rtl/split_frame_length.sv
// Splits a length-prefixed stream into header beats and frame beats, checks the frame length.
// Zero-latency combinational routing; s_axis_tready follows the ready of whichever output is active.
module split_frame_length #(
    parameter int DATA_WIDTH   = 8,
    parameter int LENGTH_BEATS = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [DATA_WIDTH-1:0]                m_axis_frame_length_tdata,
    output logic                                 m_axis_frame_length_tvalid,
    input  logic                                 m_axis_frame_length_tready,
    output logic                                 m_axis_frame_length_tlast,
    output logic [DATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [LENGTH_BEATS*DATA_WIDTH-1:0]   frame_length,
    output logic                                 frame_length_valid,
    output logic                                 err_short,
    output logic                                 err_long,
    output logic                                 err_header,
    output logic [15:0]                          frame_count,
    output logic [15:0]                          err_count
);
    localparam int LW = LENGTH_BEATS * DATA_WIDTH;
    localparam int HW = (LENGTH_BEATS > 1) ? $clog2(LENGTH_BEATS) : 1;
    localparam logic [HW-1:0] HLAST = HW'(LENGTH_BEATS - 1);

    typedef enum logic {HDR, DATA} state_t;

    state_t          state;
    logic [HW-1:0]   hidx;
    logic [LW-1:0]   len_sr;
    logic [LW-1:0]   len_next;
    logic [LW-1:0]   beat_cnt;
    logic [LW-1:0]   beat_next;
    logic            in_hdr;
    logic            hdr_hs;
    logic            dat_hs;

    always_comb begin
        in_hdr                     = (state == HDR);
        m_axis_frame_length_tdata  = s_axis_tdata;
        m_axis_tdata               = s_axis_tdata;
        m_axis_frame_length_tvalid = in_hdr & s_axis_tvalid;
        // A header beat carrying input tlast is also closed off on the length stream.
        m_axis_frame_length_tlast  = in_hdr & ((hidx == HLAST) | s_axis_tlast);
        m_axis_tvalid              = ~in_hdr & s_axis_tvalid;
        m_axis_tlast               = ~in_hdr & s_axis_tlast;
        s_axis_tready              = in_hdr ? m_axis_frame_length_tready : m_axis_tready;
        hdr_hs                     = in_hdr & s_axis_tvalid & m_axis_frame_length_tready;
        dat_hs                     = ~in_hdr & s_axis_tvalid & m_axis_tready;
        // First header beat ends up in the MSBs after LENGTH_BEATS shifts.
        len_next                   = (len_sr << DATA_WIDTH) | LW'(s_axis_tdata);
        beat_next                  = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state              <= HDR;
            hidx               <= '0;
            len_sr             <= '0;
            beat_cnt           <= '0;
            frame_length       <= '0;
            frame_length_valid <= 1'b0;
            err_short          <= 1'b0;
            err_long           <= 1'b0;
            err_header         <= 1'b0;
            frame_count        <= '0;
            err_count          <= '0;
        end else begin
            frame_length_valid <= 1'b0;
            err_short          <= 1'b0;
            err_long           <= 1'b0;
            err_header         <= 1'b0;

            if ((err_short | err_long | err_header) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;

            if (hdr_hs) begin
                len_sr <= len_next;
                if (s_axis_tlast) begin
                    err_header <= 1'b1;
                    hidx       <= '0;
                end else if (hidx == HLAST) begin
                    frame_length       <= len_next;
                    frame_length_valid <= 1'b1;
                    state              <= DATA;
                    hidx               <= '0;
                    beat_cnt           <= '0;
                end else begin
                    hidx <= hidx + HW'(1);
                end
            end

            if (dat_hs) begin
                beat_cnt <= beat_next;
                if (s_axis_tlast) begin
                    if (beat_next < frame_length)
                        err_short <= 1'b1;
                    else if (beat_next > frame_length)
                        err_long <= 1'b1;
                    if (frame_count != 16'hFFFF)
                        frame_count <= frame_count + 16'd1;
                    state <= HDR;
                end
            end
        end
    end
endmodule

// File: tb/tb_split_frame_length.sv
// Directed bench for split_frame_length: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_split_frame_length;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [7:0]  fl_tdata;
    logic        fl_tvalid;
    logic        fl_rdy = 1'b1;
    logic        fl_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_rdy = 1'b1;
    logic        m_tlast;
    logic [15:0] frame_length;
    logic        flv;
    logic        err_short, err_long, err_header;
    logic [15:0] frame_count, err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    bit in_hdr = 1'b1;
    bit rand_mode = 1'b0;
    logic [15:0] cur_len = '0;

    logic [8:0]  qlen[$];
    logic [8:0]  qdat[$];
    logic [15:0] qfl[$];
    logic [2:0]  qerr[$];

    split_frame_length #(.DATA_WIDTH(8), .LENGTH_BEATS(2)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_frame_length_tdata(fl_tdata), .m_axis_frame_length_tvalid(fl_tvalid),
        .m_axis_frame_length_tready(fl_rdy), .m_axis_frame_length_tlast(fl_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_rdy), .m_axis_tlast(m_tlast),
        .frame_length(frame_length), .frame_length_valid(flv),
        .err_short(err_short), .err_long(err_long), .err_header(err_header),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                fl_rdy = 1'($urandom_range(0, 1));
                m_rdy  = 1'($urandom_range(0, 1));
            end else begin
                fl_rdy = 1'b1;
                m_rdy  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (s_tvalid) begin
                chk("tready_mirror", 32'(s_tready), 32'(in_hdr ? fl_rdy : m_rdy));
                chk("route_sel", {30'd0, fl_tvalid, m_tvalid}, in_hdr ? 32'd2 : 32'd1);
            end
            if (fl_tvalid && fl_rdy) begin
                if (qlen.size() == 0) chk("len_unexpected", 32'(fl_tdata), 32'hFFFF_FFFF);
                else chk("len_beat", {23'd0, fl_tlast, fl_tdata}, 32'(qlen.pop_front()));
            end
            if (m_tvalid && m_rdy) begin
                if (qdat.size() == 0) chk("dat_unexpected", 32'(m_tdata), 32'hFFFF_FFFF);
                else chk("dat_beat", {23'd0, m_tlast, m_tdata}, 32'(qdat.pop_front()));
            end
            if (flv) begin
                if (qfl.size() == 0) chk("flv_unexpected", 32'(frame_length), 32'hFFFF_FFFF);
                else chk("frame_length", 32'(frame_length), 32'(qfl.pop_front()));
            end
            if (err_short || err_long || err_header) begin
                if (qerr.size() == 0) chk("err_unexpected", {29'd0, err_header, err_long, err_short}, 32'd0);
                else chk("err_kind", {29'd0, err_header, err_long, err_short}, 32'(qerr.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [15:0] len);
        cur_len = len;
        in_hdr  = 1'b1;
        qlen.push_back({1'b0, len[15:8]});
        qlen.push_back({1'b1, len[7:0]});
        qfl.push_back(len);
        send(len[15:8], 1'b0);
        send(len[7:0], 1'b0);
    endtask

    task automatic hdr_bad(input logic [7:0] d);
        in_hdr = 1'b1;
        qlen.push_back({1'b1, d});
        qerr.push_back(3'b100);
        send(d, 1'b1);
    endtask

    task automatic data(input int n, input int base, input bit last);
        in_hdr = 1'b0;
        if (last) begin
            if (n < int'(cur_len)) qerr.push_back(3'b001);
            else if (n > int'(cur_len)) qerr.push_back(3'b010);
        end
        for (int i = 0; i < n; i++) begin
            qdat.push_back({last && (i == n - 1), 8'(base + i)});
            send(8'(base + i), last && (i == n - 1));
        end
        if (last) in_hdr = 1'b1;
    endtask

    task automatic idle(input int k);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_frame_length", 32'(frame_length), 32'd0);
        chk("rst_pulses", {28'd0, flv, err_short, err_long, err_header}, 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_m_tvalid_idle", {30'd0, fl_tvalid, m_tvalid}, 32'd0);
        s_tvalid = 1'b1;
        #1;
        chk("rst_hdr_routing", {30'd0, fl_tvalid, m_tvalid}, 32'd2);
        s_tvalid = 1'b0;
    endtask

    task automatic check_counts(input int fc, input int ec);
        chk("frame_count", 32'(frame_count), 32'(fc));
        chk("err_count", 32'(err_count), 32'(ec));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rstn = 1'b1;

        hdr(16'h0040);
        data(64, 1, 1'b1);
        idle(3);
        check_counts(1, 0);

        hdr(16'h0040);
        data(60, 8'h80, 1'b1);
        idle(3);
        check_counts(2, 1);

        t0 = cyc;
        hdr(16'h0003);
        data(5, 8'h10, 1'b1);
        hdr(16'h0002);
        data(2, 8'h20, 1'b1);
        chk("b2b_cycles", 32'(cyc - t0), 32'd11);
        idle(3);
        check_counts(4, 2);

        hdr_bad(8'h00);
        hdr(16'h0004);
        data(4, 8'h30, 1'b1);
        idle(3);
        check_counts(5, 3);
        chk("len_after_bad_hdr", 32'(frame_length), 32'd4);

        rand_mode = 1'b1;
        hdr(16'h0008);
        data(8, 8'h40, 1'b1);
        hdr(16'h0005);
        data(5, 8'h50, 1'b1);
        rand_mode = 1'b0;
        idle(3);
        check_counts(7, 3);

        hdr(16'h0040);
        data(10, 8'h60, 1'b0);
        s_tvalid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_reset();
        rstn = 1'b1;
        in_hdr = 1'b1;

        hdr(16'h0002);
        data(2, 8'hA0, 1'b1);
        hdr(16'h0000);
        data(1, 8'hB0, 1'b1);
        idle(5);
        check_counts(2, 1);

        chk("qlen_empty", 32'(qlen.size()), 32'd0);
        chk("qdat_empty", 32'(qdat.size()), 32'd0);
        chk("qfl_empty", 32'(qfl.size()), 32'd0);
        chk("qerr_empty", 32'(qerr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
